// File: rtl/hough_pre_seq.sv
// Sequencer for the Hough-vote datapath: sweeps N_PHI angle steps per edge pixel, then runs block_post.
// Latency: pixel accept to first vote 4 cycles, 4 cycles per later vote, done 1 cycle after j_gt_1000.
// Backpressure: a vote_ready stall holds VOTE with no datapath writes; pix_ready is high only in IDLE.
module hough_pre_seq #(
    parameter int          N_PHI         = 180,
    parameter logic [10:0] CTRL_POST_RUN = 11'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_valid,
    input  logic [15:0] pix_x,
    input  logic [15:0] pix_y,
    output logic        pix_ready,
    input  logic        frame_end,
    output logic [15:0] x,
    output logic [15:0] y,
    output logic [29:0] ctrl_pre,
    output logic [10:0] ctrl_post,
    output logic        reset_pre,
    output logic        reset_post,
    input  logic [15:0] r_pre,
    input  logic        j_gt_1000,
    output logic        vote_valid,
    output logic [7:0]  vote_phi,
    output logic [15:0] vote_r,
    input  logic        vote_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_ANG,
        S_XCOS,
        S_YSIN,
        S_RSUM,
        S_VOTE,
        S_POSTRST,
        S_POST
    } state_t;

    typedef struct packed {
        logic [6:0] mul_a;
        logic [6:0] mul_b;
        logic [4:0] add_a;
        logic [3:0] add_b;
        logic       wr1;
        logic       wr2;
        logic       wr3;
        logic [2:0] ctrl_adder;
        logic       smux_gt90;
    } ctrl_pre_t;

    localparam logic [7:0] PHI_LAST = 8'(N_PHI - 1);

    state_t    state;
    state_t    state_nxt;
    ctrl_pre_t ctrl;
    logic [7:0] phi_cnt;
    logic       last_phi;

    assign last_phi = (phi_cnt == PHI_LAST);
    assign vote_phi = phi_cnt;
    assign ctrl_pre = ctrl;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                // a waiting pixel is served before the frame is closed
                if (pix_valid) begin
                    state_nxt = S_LOAD;
                end else if (frame_end) begin
                    state_nxt = S_POSTRST;
                end
            end
            S_LOAD:    state_nxt = S_XCOS;
            S_ANG:     state_nxt = S_XCOS;
            S_XCOS:    state_nxt = S_YSIN;
            S_YSIN:    state_nxt = S_RSUM;
            S_RSUM:    state_nxt = S_VOTE;
            S_VOTE: begin
                if (vote_ready) begin
                    state_nxt = last_phi ? S_IDLE : S_ANG;
                end
            end
            S_POSTRST: state_nxt = S_POST;
            S_POST: begin
                if (j_gt_1000) begin
                    state_nxt = S_IDLE;
                end
            end
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ctrl       = '0;
        ctrl_post  = '0;
        reset_pre  = 1'b0;
        reset_post = 1'b0;
        pix_ready  = 1'b0;
        vote_valid = 1'b0;
        busy       = (state != S_IDLE);
        case (state)
            S_IDLE:    pix_ready = 1'b1;
            S_LOAD:    reset_pre = 1'b1;
            S_XCOS: begin
                ctrl.mul_a[6] = 1'b1;
                ctrl.mul_b[3] = 1'b1;
                ctrl.wr2      = 1'b1;
            end
            S_YSIN: begin
                ctrl.mul_a[5] = 1'b1;
                ctrl.mul_b[4] = 1'b1;
                ctrl.wr3      = 1'b1;
            end
            S_RSUM: begin
                // R3 + R2 is routed back through the multiplier as K * out_add to form r
                ctrl.add_a[3] = 1'b1;
                ctrl.add_b[2] = 1'b1;
                ctrl.mul_a[4] = 1'b1;
                ctrl.mul_b[5] = 1'b1;
            end
            S_VOTE:    vote_valid = 1'b1;
            S_ANG: begin
                ctrl.add_a[2]         = 1'b1;
                ctrl.add_b[3]         = 1'b1;
                ctrl.wr1              = 1'b1;
                ctrl.ctrl_adder[2]    = 1'b1;
            end
            S_POSTRST: reset_post = 1'b1;
            S_POST:    ctrl_post = CTRL_POST_RUN;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x       <= '0;
            y       <= '0;
            phi_cnt <= '0;
            vote_r  <= '0;
            done    <= 1'b0;
        end else begin
            done <= (state == S_POST) && j_gt_1000;
            if (pix_ready && pix_valid) begin
                x       <= pix_x;
                y       <= pix_y;
                phi_cnt <= '0;
            end
            if (state == S_ANG) begin
                phi_cnt <= phi_cnt + 8'd1;
            end
            if (state == S_RSUM) begin
                vote_r <= r_pre;
            end
        end
    end

endmodule

// File: tb/tb_hough_pre_seq.sv
// Directed bench for hough_pre_seq: sweep timing, control encodings, stalls, frame end, priority, async reset.
module tb_hough_pre_seq;

    localparam logic [29:0] C_XCOS = 30'h2008_0020;
    localparam logic [29:0] C_YSIN = 30'h1010_0010;
    localparam logic [29:0] C_RSUM = 30'h0820_4200;
    localparam logic [29:0] C_ANG  = 30'h0000_2448;
    localparam logic [10:0] C_POST = 11'h5A3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pix_valid = 1'b0;
    logic [15:0] pix_x = '0;
    logic [15:0] pix_y = '0;
    logic        pix_ready;
    logic        frame_end = 1'b0;
    logic [15:0] x;
    logic [15:0] y;
    logic [29:0] ctrl_pre;
    logic [10:0] ctrl_post;
    logic        reset_pre;
    logic        reset_post;
    logic [15:0] r_pre = '0;
    logic        j_gt_1000 = 1'b0;
    logic        vote_valid;
    logic [7:0]  vote_phi;
    logic [15:0] vote_r;
    logic        vote_ready = 1'b0;
    logic        busy;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hough_pre_seq #(.N_PHI(180), .CTRL_POST_RUN(C_POST)) dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_ready(pix_ready), .frame_end(frame_end), .x(x), .y(y), .ctrl_pre(ctrl_pre),
        .ctrl_post(ctrl_post), .reset_pre(reset_pre), .reset_post(reset_post), .r_pre(r_pre),
        .j_gt_1000(j_gt_1000), .vote_valid(vote_valid), .vote_phi(vote_phi), .vote_r(vote_r),
        .vote_ready(vote_ready), .busy(busy), .done(done)
    );

    task automatic test_reset();
        reset = 1'b0;
        #12;
        n_tests++;
        if ({pix_ready, busy, vote_valid, reset_pre, reset_post, done} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 100000",
                     {pix_ready, busy, vote_valid, reset_pre, reset_post, done});
        end
        n_tests++;
        if ({ctrl_pre, ctrl_post} !== 41'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got pre=%h post=%h want 0", ctrl_pre, ctrl_post);
        end
        n_tests++;
        if ({x, y, vote_phi, vote_r} !== 56'd0) begin
            n_fail++;
            $display("FAIL reset_regs: got x=%h y=%h phi=%h r=%h want 0", x, y, vote_phi, vote_r);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({pix_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_release_idle: got ready,busy=%b want 10", {pix_ready, busy});
        end
    endtask

    task automatic test_single_pixel();
        int nv = 0;
        int ready_k = -1;
        logic [29:0] exp_ctrl;
        @(negedge clk);
        n_tests++;
        if (pix_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_idle_ready: got %b want 1", pix_ready);
        end
        pix_x = 16'd10; pix_y = 16'd0; r_pre = 16'hA500; vote_ready = 1'b1; pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        n_tests++;
        if ({x, y} !== {16'd10, 16'd0}) begin
            n_fail++;
            $display("FAIL single_latch_xy: got x=%0d y=%0d want 10 0", x, y);
        end
        for (int k = 1; k <= 1000; k++) begin
            if (pix_ready) begin
                ready_k = k;
                break;
            end
            // state pattern after LOAD with vote_ready held: XCOS YSIN RSUM VOTE ANG
            exp_ctrl = '0;
            if (k >= 2) begin
                case ((k - 2) % 5)
                    0: exp_ctrl = C_XCOS;
                    1: exp_ctrl = C_YSIN;
                    2: exp_ctrl = C_RSUM;
                    4: exp_ctrl = C_ANG;
                    default: exp_ctrl = '0;
                endcase
            end
            n_tests++;
            if ({ctrl_pre, reset_pre, vote_valid} !== {exp_ctrl, k == 1, k >= 2 && (k - 2) % 5 == 3}) begin
                n_fail++;
                $display("FAIL single_ctrl k=%0d: got ctrl=%h rpre=%b vld=%b want ctrl=%h rpre=%b vld=%b",
                         k, ctrl_pre, reset_pre, vote_valid, exp_ctrl, k == 1, k >= 2 && (k - 2) % 5 == 3);
            end
            if (vote_valid) begin
                n_tests++;
                if ({vote_phi, vote_r} !== {8'(nv), 8'hA5, 8'(nv)}) begin
                    n_fail++;
                    $display("FAIL single_vote %0d: got phi=%0d r=%h want phi=%0d r=%h",
                             nv, vote_phi, vote_r, nv, {8'hA5, 8'(nv)});
                end
                nv++;
                r_pre = {8'hA5, 8'(nv)};
            end
            @(negedge clk);
        end
        n_tests++;
        if (ready_k != 901) begin
            n_fail++;
            $display("FAIL single_ready_again: got cycle %0d want 901", ready_k);
        end
        n_tests++;
        if (nv != 180) begin
            n_fail++;
            $display("FAIL single_vote_count: got %0d want 180", nv);
        end
    endtask

    task automatic test_backpressure();
        int nv = 0;
        bit stalled = 0;
        bit idle_seen = 0;
        pix_x = 16'd3; pix_y = 16'd7; r_pre = 16'hA500; vote_ready = 1'b1; pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (pix_ready) begin
                idle_seen = 1;
                break;
            end
            if (vote_valid) begin
                n_tests++;
                if ({vote_phi, vote_r} !== {8'(nv), 8'hA5, 8'(nv)}) begin
                    n_fail++;
                    $display("FAIL bp_vote %0d: got phi=%0d r=%h want phi=%0d r=%h",
                             nv, vote_phi, vote_r, nv, {8'hA5, 8'(nv)});
                end
                if (nv == 5 && !stalled) begin
                    stalled = 1;
                    vote_ready = 1'b0;
                    r_pre = 16'hDEAD;
                    for (int s = 0; s < 7; s++) begin
                        @(negedge clk);
                        n_tests++;
                        if ({vote_valid, vote_phi, vote_r, ctrl_pre, reset_pre} !==
                            {1'b1, 8'd5, 16'hA505, 30'd0, 1'b0}) begin
                            n_fail++;
                            $display("FAIL bp_stall %0d: got vld=%b phi=%0d r=%h ctrl=%h rpre=%b want 1 5 a505 0 0",
                                     s, vote_valid, vote_phi, vote_r, ctrl_pre, reset_pre);
                        end
                    end
                    vote_ready = 1'b1;
                end
                nv++;
                r_pre = {8'hA5, 8'(nv)};
            end
            @(negedge clk);
        end
        n_tests++;
        if (!idle_seen || nv != 180 || {x, y} !== {16'd3, 16'd7}) begin
            n_fail++;
            $display("FAIL bp_complete: got idle=%0d votes=%0d x=%0d y=%0d want 1 180 3 7", idle_seen, nv, x, y);
        end
    endtask

    task automatic test_frame_end();
        @(negedge clk);
        frame_end = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({reset_post, ctrl_post, busy, pix_ready} !== {1'b1, 11'd0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL fe_postrst: got rpost=%b cpost=%h busy=%b rdy=%b want 1 000 1 0",
                     reset_post, ctrl_post, busy, pix_ready);
        end
        frame_end = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_tests++;
            if ({reset_post, ctrl_post, done, busy} !== {1'b0, C_POST, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL fe_post %0d: got rpost=%b cpost=%h done=%b busy=%b want 0 5a3 0 1",
                         i, reset_post, ctrl_post, done, busy);
            end
        end
        j_gt_1000 = 1'b1;
        @(negedge clk);
        j_gt_1000 = 1'b0;
        n_tests++;
        if ({done, pix_ready, busy, ctrl_post} !== {1'b1, 1'b1, 1'b0, 11'd0}) begin
            n_fail++;
            $display("FAIL fe_done: got done=%b rdy=%b busy=%b cpost=%h want 1 1 0 000",
                     done, pix_ready, busy, ctrl_post);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if ({done, pix_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL fe_done_once %0d: got done,rdy=%b want 01", i, {done, pix_ready});
            end
        end
    endtask

    task automatic test_priority();
        int nv = 0;
        bit rpost_seen = 0;
        pix_x = 16'd5; pix_y = 16'd5; r_pre = 16'hA500; vote_ready = 1'b1;
        pix_valid = 1'b1; frame_end = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        n_tests++;
        if ({reset_pre, reset_post} !== 2'b10) begin
            n_fail++;
            $display("FAIL prio_load_first: got rpre,rpost=%b want 10", {reset_pre, reset_post});
        end
        for (int c = 0; c < 1200; c++) begin
            if (pix_ready) break;
            if (reset_post) rpost_seen = 1;
            if (vote_valid) begin
                nv++;
                r_pre = {8'hA5, 8'(nv)};
            end
            @(negedge clk);
        end
        n_tests++;
        if (nv != 180 || rpost_seen || pix_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_sweep: got votes=%0d rpost_seen=%0d rdy=%b want 180 0 1", nv, rpost_seen, pix_ready);
        end
        @(negedge clk);
        frame_end = 1'b0;
        n_tests++;
        if (reset_post !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_postrst: got rpost=%b want 1", reset_post);
        end
        @(negedge clk);
        n_tests++;
        if (ctrl_post !== C_POST) begin
            n_fail++;
            $display("FAIL prio_post: got cpost=%h want 5a3", ctrl_post);
        end
        j_gt_1000 = 1'b1;
        @(negedge clk);
        j_gt_1000 = 1'b0;
        n_tests++;
        if ({done, pix_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL prio_done: got done,rdy=%b want 11", {done, pix_ready});
        end
    endtask

    task automatic test_async_reset();
        int nv = 0;
        bit idle_seen = 0;
        @(negedge clk);
        pix_x = 16'd20; pix_y = 16'd30; r_pre = 16'hA500; vote_ready = 1'b1; pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (vote_valid) begin
                nv++;
                r_pre = {8'hA5, 8'(nv)};
                if (vote_phi == 8'd89) break;
            end
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if ({ctrl_pre, vote_phi} !== {C_YSIN, 8'd90}) begin
            n_fail++;
            $display("FAIL ar_in_ysin: got ctrl=%h phi=%0d want %h 90", ctrl_pre, vote_phi, C_YSIN);
        end
        #2 reset = 1'b0;
        #1;
        n_tests++;
        if ({pix_ready, busy, vote_valid, reset_pre, reset_post, done, ctrl_pre, ctrl_post} !==
            {6'b100000, 41'd0}) begin
            n_fail++;
            $display("FAIL ar_outputs: got rdy=%b busy=%b vld=%b ctrl=%h cpost=%h want 1 0 0 0 0",
                     pix_ready, busy, vote_valid, ctrl_pre, ctrl_post);
        end
        n_tests++;
        if ({x, y, vote_phi, vote_r} !== 56'd0) begin
            n_fail++;
            $display("FAIL ar_regs: got x=%h y=%h phi=%h r=%h want 0", x, y, vote_phi, vote_r);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        nv = 0;
        pix_x = 16'd1; pix_y = 16'd2; r_pre = 16'hA500; pix_valid = 1'b1;
        @(negedge clk);
        pix_valid = 1'b0;
        for (int c = 0; c < 1200; c++) begin
            if (pix_ready) begin
                idle_seen = 1;
                break;
            end
            if (vote_valid) begin
                n_tests++;
                if ({vote_phi, vote_r} !== {8'(nv), 8'hA5, 8'(nv)}) begin
                    n_fail++;
                    $display("FAIL ar_resweep %0d: got phi=%0d r=%h want phi=%0d r=%h",
                             nv, vote_phi, vote_r, nv, {8'hA5, 8'(nv)});
                end
                nv++;
                r_pre = {8'hA5, 8'(nv)};
            end
            @(negedge clk);
        end
        n_tests++;
        if (!idle_seen || nv != 180 || {x, y} !== {16'd1, 16'd2}) begin
            n_fail++;
            $display("FAIL ar_complete: got idle=%0d votes=%0d x=%0d y=%0d want 1 180 1 2", idle_seen, nv, x, y);
        end
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_backpressure();
        test_frame_end();
        test_priority();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end

endmodule

// File: doc/hough_pre_seq.md
# hough_pre_seq

Sequencer for the Hough-vote datapath. It accepts edge pixels over a valid/ready handshake and drives `ctrl_pre`, `reset_pre` and `reset_post` so that `block_pre` sweeps 180 angle steps per pixel. It emits one (phi index, r) vote per step to the accumulator over a second handshake. After the frame it runs the `block_post` line-extraction phase until `j_gt_1000`. It sits between the edge-pixel FIFO and `block_pre`/accumulator.

## Interface
**Parameters**
- `N_PHI`, 180: angle steps per pixel.
- `CTRL_POST_RUN`, 11'h000: `ctrl_post` word driven during the POST phase.

**Ports**
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `pix_valid` in 1: edge pixel available.
- `pix_x`, `pix_y` in 16 each: pixel coordinates.
- `pix_ready` out 1: pixel accepted this cycle.
- `frame_end` in 1: level; no further pixels this frame.
- `x`, `y` out 16 each: latched pixel, to `block_pre`.
- `ctrl_pre` out 30: `{mulA[6:0], mulB[6:0], addA[4:0], addB[3:0], wR1, wR2, wR3, ctrl_adder[2:0], smux_gt90}`.
- `ctrl_post` out 11: to `block_post`.
- `reset_pre`, `reset_post` out 1 each: active-high datapath clears.
- `r_pre` in 16: r result from `block_pre`.
- `j_gt_1000` in 1: post phase complete.
- `vote_valid` out 1: vote presented.
- `vote_phi` out 8: angle index.
- `vote_r` out 16: r value.
- `vote_ready` in 1: accumulator accepts.
- `busy` out 1: not IDLE.
- `done` out 1: one-cycle pulse at end of POST.

## Operation
**States:** IDLE, LOAD, ANG, XCOS, YSIN, RSUM, VOTE, POSTRST, POST.

- **IDLE**
  - `pix_ready = 1`.
  - On `pix_valid`: latch `x`/`y`, clear phi counter, go to LOAD.
  - Else if `frame_end`: go to POSTRST.
  - If `pix_valid` and `frame_end` are both high, the pixel wins.
- **LOAD**
  - `reset_pre = 1` (R1 ← 0), `ctrl_pre = 0`.
  - Go to XCOS.
- **XCOS**
  - mulA[6] (x), mulB[3] (cos), wR2.
  - Go to YSIN.
- **YSIN**
  - mulA[5] (y), mulB[4] (sin), wR3.
  - Go to RSUM.
- **RSUM**
  - addA[3] (R3), addB[2] (R2), ctrl_adder = 000.
  - Capture r into `vote_r`: the sum is presented to the mul path via mulA[4] (K) and mulB[5] (out_add), and `vote_r` takes `r_pre`.
  - Go to VOTE.
- **VOTE**
  - `vote_valid = 1`, `ctrl_pre = 0` (registers hold).
  - On `vote_ready`: if phi counter = N_PHI−1, go to IDLE; else go to ANG.
- **ANG**
  - addA[2] (denta_phi), addB[3] (R1), wR1, ctrl_adder[2] = 1 (gt_90 fold), smux_gt90 = 0.
  - Increment phi counter.
  - Go to XCOS.
- **POSTRST**
  - `reset_post = 1` for one cycle.
  - Go to POST.
- **POST**
  - `ctrl_post = CTRL_POST_RUN`.
  - On `j_gt_1000`: pulse `done`, go to IDLE.
  - `frame_end` must be deasserted before the next frame.

**Arithmetic and sequencing rules**
- Phi counter is 8-bit, range 0..N_PHI−1, with no wrap inside a pixel.
- All control outputs are Moore (a function of state only). `pix_ready` and `vote_valid` are combinational from state.
- `vote_phi` and `vote_r` are stable while `vote_valid = 1`.
- Any field not listed for a state is 0. `ctrl_post = 0` outside POST.

## Timing
- Reset (async assert, sync release): state IDLE; all outputs 0 except `pix_ready = 1`; `x`, `y`, `vote_r`, `vote_phi` = 0.
- Pixel accept to first `vote_valid`: 4 cycles (LOAD, XCOS, YSIN, RSUM).
- Later votes: 4 cycles each (ANG, XCOS, YSIN, RSUM) after the previous handshake.
- Minimum per pixel: 1 + 3 + 179×4 + 180 VOTE = 900 cycles with `vote_ready` held high.
- A `vote_ready` stall holds VOTE indefinitely, with no datapath writes.
- `pix_ready` is high only in IDLE. A pixel arriving mid-sweep waits.
- Reset asserted mid-operation returns to IDLE immediately and drops `vote_valid` in the same cycle. The pending vote is lost.

## Test plan
- **Single pixel:** pixel (x=10, y=0), `vote_ready` = 1 → exactly 180 votes with phi 0..179 in order; `pix_ready` high again at cycle 901.
- **Backpressure:** hold `vote_ready` = 0 for 7 cycles at phi=5 → `vote_valid`, `vote_phi` = 5 and `vote_r` stay stable; `ctrl_pre` = 0 throughout; sweep resumes correctly.
- **Control encoding:** in each state, `ctrl_pre` equals the field encoding above; `reset_pre` is high only in LOAD.
- **Frame end:** assert `frame_end` in IDLE → `reset_post` pulses 1 cycle; `ctrl_post` = CTRL_POST_RUN; `j_gt_1000` after 20 cycles → `done` pulses once, return to IDLE.
- **Priority:** `pix_valid` and `frame_end` high together → pixel is accepted first; POST starts after its 180 votes.
- **Async reset:** drive reset low at phi=90 in YSIN → all outputs go to their reset values without a clock edge; after release the next pixel sweeps from phi 0.
